// File: rtl/psum_accum_buffer_pkg.sv
// -----------------------------------------------------------------------------
// psum_accum_buffer_pkg
// Shared definitions for the partial-sum pipeline: input field positions of the
// 24-bit {x, y, psum} beat, default accumulator width and tile edge, and the
// accumulate/drain state encoding. Also used by the index-check stage and the
// output writer.
// -----------------------------------------------------------------------------
package psum_accum_buffer_pkg;

  // Field positions inside the 24-bit input beat {x[3:0], y[3:0], psum[15:0]}
  localparam int X_MSB  = 23;
  localparam int X_LSB  = 20;
  localparam int Y_MSB  = 19;
  localparam int Y_LSB  = 16;
  localparam int PSUM_W = 16;

  // Defaults for the buffer geometry
  localparam int ACC_W_DEF = 24;
  localparam int DIM_DEF   = 16;

  // FSM encoding
  localparam logic ACCUM = 1'b0;
  localparam logic DRAIN = 1'b1;

endpackage

// File: rtl/psum_acc_adder.sv
// -----------------------------------------------------------------------------
// psum_acc_adder
// Combinational sign-extend-and-add used for the scatter-accumulate update.
// Default build: result wraps modulo 2^ACC_W.
// With ACCUM_SAT_EN defined: result saturates to the signed ACC_W range and
// 'clipped' reports that the saturation kicked in.
//
// Ports:
//   acc     in   ACC_W   current entry value
//   psum    in   PSUM_W  signed partial sum
//   sum     out  ACC_W   updated entry value
//   clipped out  1       (ACCUM_SAT_EN only) update was saturated
// -----------------------------------------------------------------------------
module psum_acc_adder
  import psum_accum_buffer_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  sum
`ifdef ACCUM_SAT_EN
  ,
  output logic              clipped
`endif
);

  logic [ACC_W-1:0] psum_ext;
  assign psum_ext = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};

`ifdef ACCUM_SAT_EN
  // One guard bit: overflow happened when the two top bits of the widened
  // sum disagree; the guard bit then carries the true sign.
  logic [ACC_W:0] wide;
  assign wide = {acc[ACC_W-1], acc} + {psum_ext[ACC_W-1], psum_ext};

  always_comb begin
    clipped = (wide[ACC_W] != wide[ACC_W-1]);
    sum     = wide[ACC_W-1:0];
    if (clipped) begin
      if (wide[ACC_W]) sum = {1'b1, {(ACC_W-1){1'b0}}};
      else             sum = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = acc + psum_ext;
`endif

endmodule

// File: rtl/psum_accum_buffer.sv
// -----------------------------------------------------------------------------
// psum_accum_buffer
// Scatter-accumulates signed partial sums into a DIM x DIM register tile
// addressed by {x, y}, then on drain_start streams the (dim_limit+1)^2 square
// out in row-major order (y fastest), clearing each entry as it is read.
//
// Optional feature macro: ACCUM_SAT_EN (saturating accumulate + sat_flag port).
//
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous active-low reset
//   i_data       in   24     {x[23:20], y[19:16], psum[15:0]}, psum signed
//   i_valid      in   1      i_data valid
//   drain_start  in   1      pulse: begin readout (honoured only in ACCUM)
//   dim_limit    in   4      last valid x/y index, captured at drain_start
//   o_data       out  ACC_W  entry value of current readout beat
//   o_addr       out  8      {x, y} of o_data
//   o_valid      out  1      readout beat valid
//   o_ready      in   1      downstream ready
//   o_last       out  1      final readout beat
//   busy         out  1      high while draining
//   drop_err     out  1      sticky: input beat arrived while draining
//   sat_flag     out  1      (ACCUM_SAT_EN only) sticky: an update saturated,
//                            cleared by an accepted drain_start
//
// Handshake: a readout beat transfers on a cycle where o_valid && o_ready at
// the rising edge. While o_valid is high and o_ready low, o_data, o_addr and
// o_last hold stable; o_valid never drops until its beat transfers (except on
// reset).
// -----------------------------------------------------------------------------
module psum_accum_buffer
  import psum_accum_buffer_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int DIM   = DIM_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [23:0]      i_data,
  input  logic             i_valid,
  input  logic             drain_start,
  input  logic [3:0]       dim_limit,
  output logic [ACC_W-1:0] o_data,
  output logic [7:0]       o_addr,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_last,
  output logic             busy,
  output logic             drop_err
`ifdef ACCUM_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  // FSM state, readout pointer and the dim_limit captured at drain_start
  logic             state;
  logic [3:0]       x_ptr;
  logic [3:0]       y_ptr;
  logic [3:0]       dim_q;

  logic [ACC_W-1:0] mem [DIM*DIM];

  logic [3:0]        in_x;
  logic [3:0]        in_y;
  logic [PSUM_W-1:0] in_psum;
  logic [7:0]        in_addr;
  logic [7:0]        rd_addr;
  logic              acc_en;
  logic              take;
  logic              ptr_last;
  logic [ACC_W-1:0]  acc_sum;

  assign in_x    = i_data[X_MSB:X_LSB];
  assign in_y    = i_data[Y_MSB:Y_LSB];
  assign in_psum = i_data[PSUM_W-1:0];
  assign in_addr = {in_x, in_y};
  assign rd_addr = {x_ptr, y_ptr};

  assign acc_en   = (state == ACCUM) && i_valid;
  assign take     = (state == DRAIN) && o_ready;
  assign ptr_last = (x_ptr == dim_q) && (y_ptr == dim_q);

  // Read-modify-write happens in one cycle from the register array, so
  // back-to-back hits to the same address see the freshly written value.
`ifdef ACCUM_SAT_EN
  logic clipped;
  psum_acc_adder #(.ACC_W(ACC_W)) u_adder (
    .acc     (mem[in_addr]),
    .psum    (in_psum),
    .sum     (acc_sum),
    .clipped (clipped)
  );
`else
  psum_acc_adder #(.ACC_W(ACC_W)) u_adder (
    .acc  (mem[in_addr]),
    .psum (in_psum),
    .sum  (acc_sum)
  );
`endif

  // Buffer: at most one write per cycle (accumulate in ACCUM, clear in DRAIN)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DIM*DIM; i++) mem[i] <= '0;
    end else if (acc_en) begin
      mem[in_addr] <= acc_sum;
    end else if (take) begin
      mem[rd_addr] <= '0;
    end
  end

  // FSM and readout pointer (y advances first, wraps at dim_q, then x)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ACCUM;
      x_ptr    <= '0;
      y_ptr    <= '0;
      dim_q    <= '0;
      drop_err <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (drain_start) begin
            state <= DRAIN;
            x_ptr <= '0;
            y_ptr <= '0;
            dim_q <= dim_limit;
          end
        end
        DRAIN: begin
          if (i_valid) drop_err <= 1'b1;
          if (o_ready) begin
            if (ptr_last) begin
              state <= ACCUM;
            end else if (y_ptr == dim_q) begin
              y_ptr <= '0;
              x_ptr <= x_ptr + 4'd1;
            end else begin
              y_ptr <= y_ptr + 4'd1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

`ifdef ACCUM_SAT_EN
  // A clipped update in the same cycle as drain_start wins over the clear,
  // because that beat belongs to the tile being drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= 1'b0;
    end else if (acc_en && clipped) begin
      sat_flag <= 1'b1;
    end else if ((state == ACCUM) && drain_start) begin
      sat_flag <= 1'b0;
    end
  end
`endif

  // Readout outputs are driven straight from state so that an asynchronous
  // reset removes them immediately.
  assign o_valid = (state == DRAIN);
  assign busy    = (state == DRAIN);
  assign o_addr  = o_valid ? rd_addr : 8'd0;
  assign o_data  = o_valid ? mem[rd_addr] : '0;
  assign o_last  = o_valid && ptr_last;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// -----------------------------------------------------------------------------
// tb_psum_accum_buffer
// Directed bench for psum_accum_buffer. Inputs are driven 1 time unit after
// the rising edge; outputs are checked at that same point, well away from the
// next active edge. Build with +define+ACCUM_SAT_EN to cover the saturating
// variant.
// -----------------------------------------------------------------------------
module tb_psum_accum_buffer;

  logic        clk;
  logic        reset;
  logic [23:0] i_data;
  logic        i_valid;
  logic        drain_start;
  logic [3:0]  dim_limit;
  logic [23:0] o_data;
  logic [7:0]  o_addr;
  logic        o_valid;
  logic        o_ready;
  logic        o_last;
  logic        busy;
  logic        drop_err;
`ifdef ACCUM_SAT_EN
  logic        sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  psum_accum_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .drain_start (drain_start),
    .dim_limit   (dim_limit),
    .o_data      (o_data),
    .o_addr      (o_addr),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_last      (o_last),
    .busy        (busy),
    .drop_err    (drop_err)
`ifdef ACCUM_SAT_EN
    ,
    .sat_flag    (sat_flag)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y, input logic [15:0] psum);
    i_data  = {x, y, psum};
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic start_drain(input logic [3:0] dim);
    dim_limit   = dim;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
  endtask

  // Drain a (dim+1)^2 tile with o_ready held high; every entry is expected
  // to read 0 except hot_addr, which reads hot_val.
  task automatic drain_check(input string tag, input logic [3:0] dim,
                             input logic [7:0] hot_addr, input logic [23:0] hot_val);
    logic [7:0]  ea;
    logic [23:0] ed;
    o_ready = 1'b1;
    start_drain(dim);
    for (int xi = 0; xi <= int'(dim); xi++) begin
      for (int yi = 0; yi <= int'(dim); yi++) begin
        ea = {4'(xi), 4'(yi)};
        ed = (ea == hot_addr) ? hot_val : 24'd0;
        check({tag, " o_valid"}, 32'(o_valid), 32'd1);
        check({tag, " o_addr"},  32'(o_addr),  32'(ea));
        check({tag, " o_data"},  32'(o_data),  32'(ed));
        check({tag, " o_last"},  32'(o_last),
              32'((xi == int'(dim)) && (yi == int'(dim))));
        tick();
      end
    end
    check({tag, " idle o_valid"}, 32'(o_valid), 32'd0);
    check({tag, " idle busy"},    32'(busy),    32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // directed sequence
  // ---------------------------------------------------------------------------
  logic [7:0]  s_addr [4];
  logic [23:0] s_data [4];

  initial begin
    reset       = 1'b0;
    i_data      = '0;
    i_valid     = 1'b0;
    drain_start = 1'b0;
    dim_limit   = '0;
    o_ready     = 1'b1;

    // reset state
    #3;
    check("reset o_valid",  32'(o_valid),  32'd0);
    check("reset busy",     32'(busy),     32'd0);
    check("reset drop_err", 32'(drop_err), 32'd0);
    check("reset o_last",   32'(o_last),   32'd0);
    check("reset o_data",   32'(o_data),   32'd0);
    check("reset o_addr",   32'(o_addr),   32'd0);
`ifdef ACCUM_SAT_EN
    check("reset sat_flag", 32'(sat_flag), 32'd0);
`endif
    #7 reset = 1'b1;
    tick();

    // 5 + (-2) + 0x7FFF back-to-back to (2,3) = 0x8002
    send(4'd2, 4'd3, 16'd5);
    send(4'd2, 4'd3, 16'hFFFE);
    send(4'd2, 4'd3, 16'h7FFF);
    drain_check("t1", 4'd3, 8'h23, 24'h008002);

    // dim_limit=1 with stalls on the odd beats
    send(4'd0, 4'd0, 16'd1);
    send(4'd0, 4'd1, 16'd2);
    send(4'd1, 4'd0, 16'd3);
    send(4'd1, 4'd1, 16'd4);
    s_addr = '{8'h00, 8'h01, 8'h10, 8'h11};
    s_data = '{24'd1, 24'd2, 24'd3, 24'd4};
    start_drain(4'd1);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 1) begin
        o_ready = 1'b0;
        repeat (2) begin
          check("t2 stall o_valid", 32'(o_valid), 32'd1);
          check("t2 stall o_addr",  32'(o_addr),  32'(s_addr[k]));
          check("t2 stall o_data",  32'(o_data),  32'(s_data[k]));
          check("t2 stall o_last",  32'(o_last),  32'(k == 3));
          tick();
        end
        o_ready = 1'b1;
      end
      check("t2 o_addr", 32'(o_addr), 32'(s_addr[k]));
      check("t2 o_data", 32'(o_data), 32'(s_data[k]));
      check("t2 o_last", 32'(o_last), 32'(k == 3));
      tick();
    end
    check("t2 idle o_valid", 32'(o_valid), 32'd0);
    drain_check("t2 clear", 4'd1, 8'hFF, 24'd0);

    // drain_start together with i_valid; then a dropped beat during DRAIN
    o_ready     = 1'b0;
    dim_limit   = 4'd0;
    i_data      = {4'd0, 4'd0, 16'd7};
    i_valid     = 1'b1;
    drain_start = 1'b1;
    tick();
    i_valid     = 1'b0;
    drain_start = 1'b0;
    check("t3 o_valid",  32'(o_valid),  32'd1);
    check("t3 busy",     32'(busy),     32'd1);
    check("t3 o_data",   32'(o_data),   32'd7);
    check("t3 o_last",   32'(o_last),   32'd1);
    check("t3 drop_err pre", 32'(drop_err), 32'd0);
    send(4'd0, 4'd0, 16'd9);
    check("t3 drop_err", 32'(drop_err), 32'd1);
    check("t3 o_data after drop", 32'(o_data), 32'd7);
    o_ready = 1'b1;
    tick();
    check("t3 idle o_valid", 32'(o_valid), 32'd0);
    drain_check("t3 clear", 4'd0, 8'hFF, 24'd0);
    check("t3 drop_err sticky", 32'(drop_err), 32'd1);

    // reset in the middle of a drain
    send(4'd1, 4'd1, 16'd5);
    o_ready = 1'b1;
    start_drain(4'd1);
    tick();
    tick();
    check("t4 third beat addr", 32'(o_addr), 32'h10);
    #2 reset = 1'b0;
    #1;
    check("t4 rst o_valid",  32'(o_valid),  32'd0);
    check("t4 rst busy",     32'(busy),     32'd0);
    check("t4 rst o_last",   32'(o_last),   32'd0);
    check("t4 rst drop_err", 32'(drop_err), 32'd0);
    #1 reset = 1'b1;
    tick();
    drain_check("t4 dim0", 4'd0, 8'hFF, 24'd0);
    drain_check("t4 dim1", 4'd1, 8'hFF, 24'd0);

    // 256*0x7FFF + 0xFF = 0x7FFFFF at (1,1), then +1
    for (int n = 0; n < 256; n++) send(4'd1, 4'd1, 16'h7FFF);
    send(4'd1, 4'd1, 16'h00FF);
`ifdef ACCUM_SAT_EN
    check("t5 sat_flag pre", 32'(sat_flag), 32'd0);
    send(4'd1, 4'd1, 16'd1);
    check("t5 sat_flag", 32'(sat_flag), 32'd1);
    drain_check("t5 sat", 4'd1, 8'h11, 24'h7FFFFF);
    check("t5 sat_flag cleared", 32'(sat_flag), 32'd0);
`else
    send(4'd1, 4'd1, 16'd1);
    drain_check("t5 wrap", 4'd1, 8'h11, 24'h800000);
`endif

    // -32768 twice = -65536
    send(4'd0, 4'd0, 16'h8000);
    send(4'd0, 4'd0, 16'h8000);
    drain_check("t6 neg", 4'd0, 8'h00, 24'hFF0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
